// File: rtl/mux8_rr_sched.sv
// Round-robin owner of one 8:1 single-bit mux channel with a one-cycle gap between owners.
// Optional hold-limit release is compiled in with `define MUX8_RR_TIMEOUT_EN (limit MAX_HOLD).
module mux8_rr_sched #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       y,
  output logic       y_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_grant;
  logic [7:0] w_grant_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic       r_y;
  logic       r_y_vld;
  logic [2:0] w_win;
  logic       w_expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("mux8_rr_sched: MAX_HOLD must be within 2..256");
  end

`ifdef MUX8_RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_cnt;

  // Count sits at zero outside BUSY, so it is already cleared on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY && w_state_nxt == ST_BUSY) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_expire = (r_state == ST_BUSY) && (r_cnt == HOLD_LAST);
`else
  assign w_expire = 1'b0;
`endif

  // Scanning offsets high-to-low leaves the lowest offset from r_ptr as the winner.
  always_comb begin
    w_win = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) begin
        w_win = r_ptr + 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = 8'b1 << w_win;
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win + 3'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (!req[r_sel] || w_expire) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_y     <= 1'b0;
      r_y_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_y     <= (|r_grant) ? d[r_sel] : 1'b0;
      r_y_vld <= |r_grant;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = r_y_vld;
  assign busy    = |r_grant;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an ownership-level reference model.
module tb_mux8_rr_sched;

  localparam int MAX_HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req   = '0;
  logic [7:0] d     = '0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .d      (d),
    .grant  (grant),
    .sel    (sel),
    .y      (y),
    .y_valid(y_valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks which requester owns the channel and how long it has held it.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_hold  = 0;
  int         m_pick;
  logic [7:0] m_grant = '0;
  logic [2:0] m_sel   = '0;
  logic       m_y     = 1'b0;
  logic       m_yv    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_grant = '0;
      m_sel   = '0;
      m_y     = 1'b0;
      m_yv    = 1'b0;
    end else begin
      m_y  = (m_grant != 0) ? d[m_sel] : 1'b0;
      m_yv = (m_grant != 0);
      if (m_owner >= 0) begin
        m_hold++;
        if (!req[m_owner]) m_owner = -1;
`ifdef MUX8_RR_TIMEOUT_EN
        else if (m_hold == MAX_HOLD) m_owner = -1;
`endif
      end else if (req != 0) begin
        m_pick = -1;
        for (int k = 0; k < 8; k++) begin
          if (m_pick < 0 && req[(m_ptr + k) % 8]) m_pick = (m_ptr + k) % 8;
        end
        m_owner = m_pick;
        m_ptr   = (m_pick + 1) % 8;
        m_hold  = 0;
      end
      if (m_owner >= 0) begin
        m_grant = 8'(1 << m_owner);
        m_sel   = 3'(m_owner);
      end else begin
        m_grant = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", 32'(grant), 32'(m_grant));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("y", 32'(y), 32'(m_y));
    chk("y_valid", 32'(y_valid), 32'(m_yv));
    chk("busy", 32'(busy), 32'(m_grant != 0));
  end

  // Applies inputs, lets one rising edge sample them, returns just after that edge.
  task automatic drive(input logic [7:0] r, input logic [7:0] dd);
    req = r;
    d   = dd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0] seq;
    logic [7:0] r;
    logic [7:0] exp_g;
    seq = 5'b01101;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'h00);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_yv", 32'(y_valid), 32'h0);
    rst_n = 1'b1;

    // Single requester with a toggling data bit.
    drive(8'h08, 8'h00);
    chk("single_grant", 32'(grant), 32'h08);
    chk("single_sel", 32'(sel), 32'h3);
    chk("single_yv_lag", 32'(y_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(8'h08, {4'b0, seq[k], 3'b0});
      chk("single_y", 32'(y), 32'(seq[k]));
      chk("single_yv", 32'(y_valid), 32'h1);
      if (k < 3) chk("single_hold", 32'(grant), 32'h08);
    end
    drive(8'h00, {4'b0, seq[4], 3'b0});
    chk("single_y_last", 32'(y), 32'(seq[4]));
    chk("single_sel_kept", 32'(sel), 32'h3);
`ifndef MUX8_RR_TIMEOUT_EN
    chk("single_gap_grant", 32'(grant), 32'h00);
    chk("single_gap_yv", 32'(y_valid), 32'h1);
`endif
    drive(8'h00, 8'h00);
    chk("single_idle_yv", 32'(y_valid), 32'h0);
    chk("single_idle_grant", 32'(grant), 32'h00);

    // Pointer wrap from 7 back to 0.
    drive(8'h80, 8'h00);
    chk("wrap_g7", 32'(grant), 32'h80);
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);
    drive(8'h81, 8'h00);
    chk("wrap_g0", 32'(grant), 32'h01);
    drive(8'h80, 8'h00);
    chk("wrap_gap1", 32'(grant), 32'h00);
    drive(8'h80, 8'h00);
    chk("wrap_g7b", 32'(grant), 32'h80);
    drive(8'h01, 8'h00);
    chk("wrap_gap2", 32'(grant), 32'h00);
    drive(8'h01, 8'h00);
    chk("wrap_g0b", 32'(grant), 32'h01);
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);

    // Owner drops while another requester is already waiting.
    drive(8'h24, 8'h00);
    chk("cont_g2", 32'(grant), 32'h04);
    drive(8'h20, 8'h00);
    chk("cont_gap", 32'(grant), 32'h00);
    drive(8'h20, 8'h00);
    chk("cont_g5", 32'(grant), 32'h20);
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);

    // Asynchronous reset while an owner is active.
    drive(8'h08, 8'hFF);
    chk("rstb_grant", 32'(grant), 32'h08);
    drive(8'h08, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("rstb_grant0", 32'(grant), 32'h00);
    chk("rstb_sel0", 32'(sel), 32'h0);
    chk("rstb_y0", 32'(y), 32'h0);
    chk("rstb_yv0", 32'(y_valid), 32'h0);
    chk("rstb_busy0", 32'(busy), 32'h0);
    @(posedge clk);
    #2;
    req   = 8'h01;
    rst_n = 1'b1;
    drive(8'h01, 8'h00);
    chk("rstb_regrant", 32'(grant), 32'h01);
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);

    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // All requesters held permanently.
`ifdef MUX8_RR_TIMEOUT_EN
    for (int s = 0; s < 45; s++) begin
      drive(8'hFF, 8'(s));
      exp_g = ((s % 5) < 4) ? 8'(1 << ((s / 5) % 8)) : 8'h00;
      chk("timeout_seq", 32'(grant), 32'(exp_g));
    end
`else
    for (int s = 0; s < 100; s++) begin
      drive(8'hFF, 8'(s));
      chk("hold_grant", 32'(grant), 32'h01);
      chk("hold_yv", 32'(y_valid), 32'(s >= 1));
    end
`endif
    drive(8'h00, 8'h00);
    drive(8'h00, 8'h00);

    // Randomized traffic: sticky request lines, random data, occasional resets.
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      r = r ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 63) == 0) r = '0;
      drive(r, 8'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    drive(8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares one 8:1 single-bit mux channel among eight requesters. It arbitrates between the request lines, drives the mux select, and holds a grant until the owner releases it or, optionally, a hold limit expires. It forwards the owner's bit onto a registered output with a valid flag. It sits between the requester blocks and the downstream serial consumer.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per ownership when the timeout is compiled in; legal range 2..256.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 8: request line per requester; held high while the requester wants the channel.
- `d` input 8: one data bit per requester; `d[i]` belongs to requester i.
- `grant` output 8: registered one-hot grant; all-zero when no owner.
- `sel` output 3: registered mux select; equals the index of the granted requester.
- `y` output 1: registered `d[sel]`, sampled while granted.
- `y_valid` output 1: high when `y` carries an owner's bit.
- `busy` output 1: equals `|grant`.

## Operation
- FSM states:
  - IDLE: no owner; arbitrates every cycle.
  - BUSY: one owner.
  - GAP: exactly one dead cycle after any release.
- Transitions:
  - IDLE→BUSY when `req != 0`.
  - BUSY→GAP when `req[owner]` is sampled low.
  - BUSY→GAP on hold expiry, when the timeout is enabled.
  - GAP→BUSY when `req != 0`.
  - GAP→IDLE otherwise.
- Arbitration:
  - Priority order starts at pointer `ptr` (3 bits) and scans `ptr, ptr+1, …` modulo 8, so index 7 wraps to 0.
  - The first set `req` bit wins.
  - On each new grant to index g, `ptr` becomes (g+1) mod 8.
- In BUSY, `grant`, `sel` and the owner stay constant. Changes on other `req` bits have no effect.
- A `req` bit that drops before it is granted is simply not selected. No request is latched.
- `sel` holds its last value in IDLE and GAP; only `grant` indicates ownership.
- Data path:
  - Every cycle, `y <= d[sel]` when `grant != 0`, else `y <= 0`.
  - Every cycle, `y_valid <= (grant != 0)`.
- Hold counter:
  - 8-bit counter, cleared on entry to BUSY.
  - Increments each BUSY cycle.
  - Expiry when count == `MAX_HOLD-1` in BUSY.
- Reset values: `grant=0`, `sel=0`, `y=0`, `y_valid=0`, `busy=0`, `ptr=0`, state IDLE, counter 0.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N gives `grant` and `sel` valid after edge N. `y_valid` rises one cycle later.
- Release: `req[owner]` sampled low at edge M gives `grant=0` after M (GAP). The earliest next grant appears after edge M+1.
- Dead time between consecutive grants is always exactly one cycle, including re-grant to the same requester.
- `y` and `y_valid` lag `grant` by one cycle; `y_valid` falls one cycle after `grant` falls.
- Same-edge release by the owner plus a new request from another requester: GAP is still inserted, and the new requester is granted after the following edge.
- Reset mid-BUSY: all outputs go to reset values immediately and asynchronously. No partial transfer is completed.

## Configuration
- `MUX8_RR_TIMEOUT_EN` defined:
  - The hold counter is present.
  - An owner is forcibly released after `MAX_HOLD` grant cycles, then GAP.
  - The released owner competes again at lowest priority.
- `MUX8_RR_TIMEOUT_EN` undefined:
  - No counter is present and `MAX_HOLD` is ignored.
  - The grant is held until the owner drops `req`; a permanently held request starves the others.

## Test plan
- Reset: assert `rst_n=0` mid-BUSY with `grant=8'h08` → outputs go to zero asynchronously; after release with `req=8'h01`, `grant=8'h01` one edge later.
- Single requester: `req=8'h08` for 5 cycles with `d[3]` toggling 1,0,1,1,0 → `grant=8'h08`, `sel=3`; `y` reproduces the sequence one cycle later with `y_valid=1`; then a 1-cycle GAP and IDLE.
- Round-robin wrap: after a grant to 7 (`ptr=0`), `req=8'h81` → grant index 0; next arbitration grants 7; next grants 0.
- Contention: `req=8'h24` with the owner (index 2) dropping on the same edge that index 5 is already pending → one GAP cycle, then `grant=8'h20`.
- Timeout (macro defined, `MAX_HOLD=4`): `req=8'hFF` held → grants 0,1,…,7,0, each exactly 4 cycles long, separated by single zero-grant cycles.
- No timeout (macro undefined): `req=8'hFF` held 100 cycles → `grant=8'h01` throughout; `y_valid` stays high from the second cycle onward.
